// File: rtl/mips_data_responder.sv
// Data-memory responder for the MIPS core: word RAM plus a switch/LED/button IO window.
// One response per accepted request; responses hold while the core stalls rsp_ready.
module mips_data_responder #(
    parameter int N = 32,
    parameter int D_WIDTH = 10,
    parameter int D_LENGTH = 513,
    parameter logic [N-1:0] IO_BASE = 32'hFFFF_0000
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_wr,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_rdata,
    output logic         rsp_err,
    input  logic [7:0]   switch,
    input  logic [4:0]   button,
    output logic [7:0]   led
);

    typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

    localparam logic [N-1:0] RAM_LIMIT = N'(4 * D_LENGTH);
    localparam logic [N-1:0] ADDR_SW   = IO_BASE;
    localparam logic [N-1:0] ADDR_LED  = IO_BASE + N'(4);
    localparam logic [N-1:0] ADDR_BTN  = IO_BASE + N'(8);

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               sel_ram_q, sel_ram_d;
    logic [N-1:0]       io_rdata_q, io_rdata_d;
    logic [N-1:0]       ram_rdata_q;
    logic [7:0]         led_q, led_d;
    logic [4:0]         sync1_q, sync2_q, btn_prev_q;
    logic [4:0]         sticky_q, sticky_d, btn_rise;
    logic [N-1:0]       mem [0:D_LENGTH-1];
    logic [D_WIDTH-1:0] widx;
    logic               accept, aligned, hit_ram, ram_we, ram_re;

    assign req_ready = rstb & ((state_q == S_IDLE) | ((state_q == S_RESP) & rsp_ready));
    assign accept    = req_valid & req_ready;
    assign widx      = req_addr[D_WIDTH+1:2];
    assign aligned   = (req_addr[1:0] == 2'b00);
    assign hit_ram   = aligned & (req_addr < RAM_LIMIT);
    assign btn_rise  = sync2_q & ~btn_prev_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        err_d      = err_q;
        sel_ram_d  = sel_ram_q;
        io_rdata_d = io_rdata_q;
        led_d      = led_q;
        sticky_d   = sticky_q | btn_rise;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        // Consumed response: clear so outputs read zero while idle.
        if (state_q == S_RESP && rsp_ready) begin
            state_d    = S_IDLE;
            valid_d    = 1'b0;
            err_d      = 1'b0;
            sel_ram_d  = 1'b0;
            io_rdata_d = '0;
        end

        if (accept) begin
            state_d    = S_RESP;
            valid_d    = 1'b1;
            err_d      = 1'b0;
            sel_ram_d  = 1'b0;
            io_rdata_d = '0;
            if (hit_ram) begin
                if (req_wr) begin
                    ram_we = 1'b1;
                end else begin
                    ram_re    = 1'b1;
                    sel_ram_d = 1'b1;
                end
            end else if (req_addr == ADDR_SW) begin
                if (req_wr) err_d = 1'b1;
                else        io_rdata_d = N'(switch);
            end else if (req_addr == ADDR_LED) begin
                if (req_wr) led_d = req_wdata[7:0];
                else        io_rdata_d = N'(led_q);
            end else if (req_addr == ADDR_BTN) begin
                if (req_wr) begin
                    err_d = 1'b1;
                end else begin
                    io_rdata_d = N'(sticky_q);
                    // A new edge on a bit being cleared wins.
                    sticky_d   = btn_rise;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            sel_ram_q  <= 1'b0;
            io_rdata_q <= '0;
            led_q      <= '0;
            sticky_q   <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            btn_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            sel_ram_q  <= sel_ram_d;
            io_rdata_q <= io_rdata_d;
            led_q      <= led_d;
            sticky_q   <= sticky_d;
            sync1_q    <= button;
            sync2_q    <= sync1_q;
            btn_prev_q <= sync2_q;
        end
    end

    // RAM is left unreset so it can map onto block memory.
    always_ff @(posedge clk) begin
        if (ram_we) mem[widx] <= req_wdata;
        if (ram_re) ram_rdata_q <= mem[widx];
    end

    assign rsp_valid = valid_q;
    assign rsp_err   = err_q;
    assign rsp_rdata = sel_ram_q ? ram_rdata_q : io_rdata_q;
    assign led       = led_q;

endmodule

// File: tb/tb_mips_data_responder.sv
// Self-checking bench for mips_data_responder: directed plan scenarios plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_mips_data_responder;

    logic        clk = 1'b0;
    logic        rstb, req_valid, req_wr, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  sw, led;
    logic [4:0]  button;

    int checks = 0;
    int errors = 0;

    mips_data_responder dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .switch(sw), .button(button), .led(led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an outstanding-response flag, a word store, and
    // buttons seen through a two-cycle delay line with edge capture.
    bit        busy = 1'b0;
    bit [31:0] e_rdata = '0;
    bit        e_err = 1'b0;
    bit        e_known = 1'b1;
    bit [7:0]  m_led = '0;
    bit [4:0]  m_sticky = '0;
    bit [4:0]  dly [0:2];
    bit [31:0] m_mem [0:512];
    bit        m_known [0:512];

    always @(posedge clk) begin : model
        bit [4:0] rise;
        bit [4:0] nxt;
        bit       take;
        int       idx;
        rise = dly[1] & ~dly[2];
        if (!rstb) begin
            busy = 0; e_rdata = 0; e_err = 0; e_known = 1;
            m_led = 0; m_sticky = 0;
            dly[0] = 0; dly[1] = 0; dly[2] = 0;
        end else begin
            nxt  = m_sticky | rise;
            take = req_valid && (!busy || rsp_ready);
            if (busy && rsp_ready) begin
                busy = 0; e_rdata = 0; e_err = 0; e_known = 1;
            end
            if (take) begin
                busy = 1; e_rdata = 0; e_err = 0; e_known = 1;
                if (req_addr[1:0] != 2'b00) begin
                    e_err = 1;
                end else if (req_addr < 32'd2052) begin
                    idx = int'(req_addr >> 2);
                    if (req_wr) begin
                        m_mem[idx] = req_wdata;
                        m_known[idx] = 1;
                    end else begin
                        e_rdata = m_mem[idx];
                        e_known = m_known[idx];
                    end
                end else if (req_addr == 32'hFFFF_0000) begin
                    if (req_wr) e_err = 1;
                    else        e_rdata = {24'b0, sw};
                end else if (req_addr == 32'hFFFF_0004) begin
                    if (req_wr) m_led = req_wdata[7:0];
                    else        e_rdata = {24'b0, m_led};
                end else if (req_addr == 32'hFFFF_0008 && !req_wr) begin
                    e_rdata = {27'b0, m_sticky};
                    nxt = rise;
                end else begin
                    e_err = 1;
                end
            end
            m_sticky = nxt;
            dly[2] = dly[1]; dly[1] = dly[0]; dly[0] = button;
        end
    end

    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready), 32'(rstb && (!busy || rsp_ready)));
        chk("rsp_valid", 32'(rsp_valid), 32'(busy));
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        if (e_known) chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("led", 32'(led), 32'(m_led));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request (responder assumed ready) and check its response.
    task automatic xact(input string name, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input bit exp_err);
        req_valid = 1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        tick();
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_rdata"}, rsp_rdata, exp_rdata);
        chk({name, "_err"}, 32'(rsp_err), 32'(exp_err));
        req_valid = 0;
    endtask

    initial begin
        rstb = 0; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
        rsp_ready = 1; sw = 8'h00; button = 5'b0;
        repeat (2) tick();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_led", 32'(led), 32'd0);
        rstb = 1;
        tick();

        xact("st_10", 1, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        xact("ld_10", 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

        for (int i = 0; i < 4; i++)
            xact("b2b_st", 1, 32'(i * 4), 32'(i + 1), 32'h0, 0);
        for (int i = 0; i < 4; i++)
            xact("b2b_ld", 0, 32'(i * 4), 32'h0, 32'(i + 1), 0);

        tick();
        rsp_ready = 0;
        req_valid = 1; req_wr = 0; req_addr = 32'h4;
        tick();
        req_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_rdata", rsp_rdata, 32'd2);
            chk("bp_ready_low", 32'(req_ready), 32'd0);
            if (i < 2) tick();
        end
        rsp_ready = 1;
        #1;
        chk("bp_ready_high", 32'(req_ready), 32'd1);
        tick();
        chk("bp_second_rdata", rsp_rdata, 32'd3);
        req_valid = 0;
        tick();

        xact("led_st", 1, 32'hFFFF_0004, 32'h0000_00A5, 32'h0, 0);
        chk("led_a5", 32'(led), 32'hA5);
        sw = 8'h3C;
        xact("sw_ld", 0, 32'hFFFF_0000, 32'h0, 32'h3C, 0);
        xact("sw_st", 1, 32'hFFFF_0000, 32'h0000_0011, 32'h0, 1);
        chk("led_kept", 32'(led), 32'hA5);
        xact("led_ld", 0, 32'hFFFF_0004, 32'h0, 32'hA5, 0);

        button = 5'b00001;
        repeat (4) tick();
        button = 5'b0;
        repeat (4) tick();
        xact("btn_ld1", 0, 32'hFFFF_0008, 32'h0, 32'h01, 0);
        xact("btn_ld2", 0, 32'hFFFF_0008, 32'h0, 32'h00, 0);
        button = 5'b00001;
        repeat (4) tick();
        button = 5'b0;
        repeat (4) tick();
        button = 5'b00001;
        tick();
        tick();
        xact("btn_coin", 0, 32'hFFFF_0008, 32'h0, 32'h01, 0);
        xact("btn_after", 0, 32'hFFFF_0008, 32'h0, 32'h01, 0);
        xact("btn_clear", 0, 32'hFFFF_0008, 32'h0, 32'h00, 0);
        button = 5'b0;

        xact("misalign", 0, 32'h2, 32'h0, 32'h0, 1);
        xact("unmapped", 0, 32'h804, 32'h0, 32'h0, 1);
        xact("last_st", 1, 32'h800, 32'h12345678, 32'h0, 0);
        xact("last_ld", 0, 32'h800, 32'h0, 32'h12345678, 0);

        tick();
        rsp_ready = 0;
        xact("rst_pend", 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        tick();
        chk("rst_pend_held", 32'(rsp_valid), 32'd1);
        rstb = 0;
        tick();
        chk("rst_drop_valid", 32'(rsp_valid), 32'd0);
        chk("rst_drop_rdata", rsp_rdata, 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        rstb = 1;
        rsp_ready = 1;
        tick();

        for (int n = 0; n < 3000; n++) begin
            int b;
            rstb      = ($urandom_range(0, 299) != 0);
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_wr    = 1'($urandom_range(0, 1));
            req_wdata = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: req_addr = 32'($urandom_range(0, 15) * 4);
                4:          req_addr = $urandom_range(0, 1) ? 32'h800 : 32'h804;
                5:          req_addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                6:          req_addr = 32'hFFFF_0000;
                7:          req_addr = 32'hFFFF_0004;
                8:          req_addr = 32'hFFFF_0008;
                default:    req_addr = $urandom_range(0, 1) ? 32'hFFFF_000C : 32'h0000_1000;
            endcase
            if (req_addr == 32'hFFFF_0008) req_wr = 0;
            if ($urandom_range(0, 15) == 0) sw = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                b = int'($urandom_range(0, 4));
                button[b] = ~button[b];
            end
            tick();
        end

        rstb = 1; req_valid = 0; rsp_ready = 1;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
